// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall / multi-cycle sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DIV_RUN  = 2'b01,
    ST_DIV_DONE = 2'b10,
    ST_MADD2    = 2'b11
  } state_t;

  // Stall vector bit map: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  localparam int STALL_W = 6;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;

  // Mask holding every stage from the PC up to and including stage hi.
  function automatic logic [STALL_W-1:0] stage_mask(input int hi);
    logic [STALL_W-1:0] m;
    m = '0;
    for (int i = 0; i < STALL_W; i++) begin
      if (i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STALL_W-1:0] STALL_NONE = '0;
  localparam logic [STALL_W-1:0] STALL_ID   = stage_mask(STG_ID);  // 000111
  localparam logic [STALL_W-1:0] STALL_EX   = stage_mask(STG_EX);  // 001111

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle of pipeline-side requests, divider handshake and stall/status outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; slave = controller, master = pipeline/divider side.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_stall_ctrl_pkg::*;

  logic               flush_i;
  logic               stallreq_id_i;
  logic               div_req_i;
  logic               div_signed_i;
  logic               madd_req_i;
  logic               div_ready_i;
  logic               div_start_o;
  logic               div_signed_o;
  logic               div_annul_o;
  logic               madd_cycle_o;
  logic [STALL_W-1:0] stall_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic               err_o;

  modport master (
    output flush_i, stallreq_id_i, div_req_i, div_signed_i, madd_req_i, div_ready_i,
    input  div_start_o, div_signed_o, div_annul_o, madd_cycle_o, stall_o, stall_cnt_o, err_o
  );

  modport slave (
    input  flush_i, stallreq_id_i, div_req_i, div_signed_i, madd_req_i, div_ready_i,
    output div_start_o, div_signed_o, div_annul_o, madd_cycle_o, stall_o, stall_cnt_o, err_o
  );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; ports: clk, rst, clear, inc -> cnt.
// Latency: 1 cycle from inc/clear to cnt.
// Backpressure: none; holds at all-ones instead of wrapping.
module pipe_stall_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Merges ID load-use and EX multi-cycle stalls into one stall vector; sequences divider and MADD.
// Latency: stall_o/div_start_o/div_annul_o combinational; state, div_signed_o, err_o, stall_cnt_o registered.
// Backpressure: stall_o is the backpressure to PC and pipeline registers; flush_i overrides everything.
// Ports: clk, rst (sync, active-high), bus (slave modport of pipe_stall_ctrl_if).
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stall_ctrl_if.slave   bus
);

  localparam int WD_W = $clog2(DIV_TIMEOUT + 1);

  state_t             state;
  state_t             state_nxt;
  logic               stallreq_ex;
  logic [STALL_W-1:0] stall;
  logic               div_start;
  logic               div_annul;
  logic               madd_cycle;
  logic               div_signed_q;
  logic               err_q;
  logic [WD_W-1:0]    wdog;
  logic               wdog_inc;
  logic               wdog_clr;
  logic [CNT_W-1:0]   stall_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.flush_i)         state_nxt = ST_IDLE;
        else if (bus.div_req_i)  state_nxt = ST_DIV_RUN;  // divide wins over MADD
        else if (bus.madd_req_i) state_nxt = ST_MADD2;
      end
      ST_DIV_RUN: begin
        if (bus.flush_i)          state_nxt = ST_IDLE;
        else if (bus.div_ready_i) state_nxt = ST_DIV_DONE;
      end
      // DIV_DONE never relaunches: the DIV leaves EX this cycle even if div_req_i is still high.
      ST_DIV_DONE: state_nxt = ST_IDLE;
      ST_MADD2:    state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    div_start   = 1'b0;
    div_annul   = 1'b0;
    madd_cycle  = 1'b0;
    stallreq_ex = 1'b0;
    case (state)
      ST_IDLE:    stallreq_ex = (bus.div_req_i || bus.madd_req_i) && !bus.flush_i;
      ST_DIV_RUN: begin
        div_start   = !bus.flush_i;
        div_annul   = bus.flush_i;  // same-cycle abort, not a registered pulse
        stallreq_ex = !bus.flush_i;
      end
      ST_MADD2:   madd_cycle = 1'b1;
      default:    ;
    endcase

    if (bus.flush_i)            stall = STALL_NONE;
    else if (stallreq_ex)       stall = STALL_EX;
    else if (bus.stallreq_id_i) stall = STALL_ID;
    else                        stall = STALL_NONE;
  end

  // Watchdog counts only the cycles the divide is still waiting; cleared whenever not in DIV_RUN.
  assign wdog_inc = (state == ST_DIV_RUN) && !bus.flush_i && !bus.div_ready_i;
  assign wdog_clr = (state != ST_DIV_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_signed_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && !bus.flush_i && bus.div_req_i) begin
        div_signed_q <= bus.div_signed_i;
      end
      // Sets on the edge where the watchdog reaches DIV_TIMEOUT; sticky until reset.
      if (wdog_inc && (wdog == WD_W'(DIV_TIMEOUT - 1))) begin
        err_q <= 1'b1;
      end
    end
  end

  pipe_stall_ctrl_sat_counter #(.W(WD_W)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wdog_clr),
    .inc   (wdog_inc),
    .cnt   (wdog)
  );

  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (stall != STALL_NONE),
    .cnt   (stall_cnt)
  );

  assign bus.stall_o      = stall;
  assign bus.div_start_o  = div_start;
  assign bus.div_annul_o  = div_annul;
  assign bus.madd_cycle_o = madd_cycle;
  assign bus.div_signed_o = div_signed_q;
  assign bus.err_o        = err_q;
  assign bus.stall_cnt_o  = stall_cnt;

endmodule
